// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEMWB retire bundle, ID read ports and debug counters of the writeback register file.
// WB_COMMIT_TRACE_EN adds the registered commit-trace signals.
interface wb_regfile_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic                  wb_enable;
    logic                  wb_reg_wen;
    logic                  wb_mem_ren;
    logic [ADDR_WIDTH-1:0] wb_rd_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DATA_WIDTH-1:0] wb_pc;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [63:0]           instret;
    logic [63:0]           loadret;
    logic [DATA_WIDTH-1:0] last_pc;
`ifdef WB_COMMIT_TRACE_EN
    logic                  commit_valid;
    logic [DATA_WIDTH-1:0] commit_pc;
    logic [ADDR_WIDTH-1:0] commit_rd;
    logic [DATA_WIDTH-1:0] commit_data;
    modport master (
        output wb_enable, wb_reg_wen, wb_mem_ren, wb_rd_addr, wb_data, wb_pc, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, instret, loadret, last_pc,
               commit_valid, commit_pc, commit_rd, commit_data
    );
    modport slave (
        input  wb_enable, wb_reg_wen, wb_mem_ren, wb_rd_addr, wb_data, wb_pc, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, instret, loadret, last_pc,
               commit_valid, commit_pc, commit_rd, commit_data
    );
`else
    modport master (
        output wb_enable, wb_reg_wen, wb_mem_ren, wb_rd_addr, wb_data, wb_pc, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, instret, loadret, last_pc
    );
    modport slave (
        input  wb_enable, wb_reg_wen, wb_mem_ren, wb_rd_addr, wb_data, wb_pc, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, instret, loadret, last_pc
    );
`endif
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback register file with same-cycle bypassed read ports and retire counters.
// WB_COMMIT_TRACE_EN adds a one-cycle-delayed commit trace (valid/pc/rd/data).
module wb_regfile #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  commit;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < REG_COUNT;
    endfunction

    assign commit = bus.wb_enable & bus.wb_reg_wen & (bus.wb_rd_addr != '0) & in_range(bus.wb_rd_addr);

    // x0 and out-of-range indices read zero ahead of the bypass
    assign bus.rs1_data = (bus.rs1_addr == '0 || !in_range(bus.rs1_addr)) ? '0 :
                          (commit && bus.rs1_addr == bus.wb_rd_addr) ? bus.wb_data : regs[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == '0 || !in_range(bus.rs2_addr)) ? '0 :
                          (commit && bus.rs2_addr == bus.wb_rd_addr) ? bus.wb_data : regs[bus.rs2_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            bus.instret <= '0;
            bus.loadret <= '0;
            bus.last_pc <= '0;
        end else begin
            if (commit) regs[bus.wb_rd_addr] <= bus.wb_data;
            if (bus.wb_enable) begin
                bus.instret <= bus.instret + 64'd1;
                bus.last_pc <= bus.wb_pc;
            end
            if (bus.wb_enable && bus.wb_mem_ren) bus.loadret <= bus.loadret + 64'd1;
        end
    end

`ifdef WB_COMMIT_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.commit_valid <= 1'b0;
            bus.commit_pc    <= '0;
            bus.commit_rd    <= '0;
            bus.commit_data  <= '0;
        end else begin
            bus.commit_valid <= bus.wb_enable;
            bus.commit_pc    <= bus.wb_enable ? bus.wb_pc : '0;
            bus.commit_rd    <= commit ? bus.wb_rd_addr : '0;
            bus.commit_data  <= commit ? bus.wb_data : '0;
        end
    end
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed stimulus pushes expected values to a scoreboard queue; a negedge monitor drains and checks it.
module tb_wb_regfile;
    typedef enum {K_RS1, K_RS2, K_INSTRET, K_LOADRET, K_LASTPC, K_TVALID, K_TPC, K_TRD, K_TDATA} kind_t;
    typedef struct {
        kind_t       k;
        logic [63:0] v;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    wb_regfile_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();
    wb_regfile #(.DATA_WIDTH(64), .REG_COUNT(32), .ADDR_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] actual(input kind_t k);
        case (k)
            K_RS1:     return bus.rs1_data;
            K_RS2:     return bus.rs2_data;
            K_INSTRET: return bus.instret;
            K_LOADRET: return bus.loadret;
            K_LASTPC:  return bus.last_pc;
`ifdef WB_COMMIT_TRACE_EN
            K_TVALID:  return 64'(bus.commit_valid);
            K_TPC:     return bus.commit_pc;
            K_TRD:     return 64'(bus.commit_rd);
            K_TDATA:   return bus.commit_data;
`endif
            default:   return 'x;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [63:0] a;
            e = sb.pop_front();
            a = actual(e.k);
            tests++;
            if (a !== e.v) begin
                fails++;
                $display("FAIL %s: got %h expected %h", e.name, a, e.v);
            end
        end
    end

    task automatic expect_v(input kind_t k, input logic [63:0] v, input string name);
        exp_t e;
        e.k = k;
        e.v = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic wen, input logic mren, input logic [4:0] rd,
                         input logic [63:0] data, input logic [63:0] pc);
        bus.wb_enable  = en;
        bus.wb_reg_wen = wen;
        bus.wb_mem_ren = mren;
        bus.wb_rd_addr = rd;
        bus.wb_data    = data;
        bus.wb_pc      = pc;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
    endtask

    initial begin
        idle();
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd31;
        expect_v(K_RS1, 64'd0, "reset_rs1");
        expect_v(K_RS2, 64'd0, "reset_rs2");
        expect_v(K_INSTRET, 64'd0, "reset_instret");
        expect_v(K_LOADRET, 64'd0, "reset_loadret");
        expect_v(K_LASTPC, 64'd0, "reset_last_pc");
`ifdef WB_COMMIT_TRACE_EN
        expect_v(K_TVALID, 64'd0, "reset_trace_valid");
`endif
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 64'hDEAD_BEEF, 64'h40);
        bus.rs1_addr = 5'd5;
        expect_v(K_RS1, 64'hDEAD_BEEF, "bypass_rs1");
        expect_v(K_INSTRET, 64'd0, "instret_before_commit");
        step();
        idle();
        expect_v(K_RS1, 64'hDEAD_BEEF, "array_rs1");
        expect_v(K_INSTRET, 64'd1, "instret_after_first");
        expect_v(K_LASTPC, 64'h40, "last_pc_first");
`ifdef WB_COMMIT_TRACE_EN
        expect_v(K_TVALID, 64'd1, "trace_valid_first");
        expect_v(K_TPC, 64'h40, "trace_pc_first");
        expect_v(K_TRD, 64'd5, "trace_rd_first");
        expect_v(K_TDATA, 64'hDEAD_BEEF, "trace_data_first");
`endif
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 64'hFFFF, 64'h44);
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        expect_v(K_RS1, 64'd0, "x0_bypass_rs1");
        expect_v(K_RS2, 64'd0, "x0_bypass_rs2");
        step();
        idle();
        expect_v(K_RS1, 64'd0, "x0_after_rs1");
        expect_v(K_INSTRET, 64'd2, "instret_x0_write");
`ifdef WB_COMMIT_TRACE_EN
        expect_v(K_TVALID, 64'd1, "trace_valid_x0");
        expect_v(K_TRD, 64'd0, "trace_rd_x0");
        expect_v(K_TDATA, 64'd0, "trace_data_x0");
`endif
        step();
        drive(1'b0, 1'b1, 1'b0, 5'd7, 64'h1234, 64'h48);
        bus.rs1_addr = 5'd7;
        expect_v(K_RS1, 64'd0, "bubble_no_bypass");
        step();
        idle();
        expect_v(K_RS1, 64'd0, "bubble_no_write");
        expect_v(K_INSTRET, 64'd2, "bubble_instret");
        expect_v(K_LASTPC, 64'h44, "bubble_last_pc");
`ifdef WB_COMMIT_TRACE_EN
        expect_v(K_TVALID, 64'd0, "trace_valid_bubble");
`endif
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 64'hA5A5_0000_0000_5A5A, 64'h4C);
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd9;
        expect_v(K_RS1, 64'hA5A5_0000_0000_5A5A, "dual_bypass_rs1");
        expect_v(K_RS2, 64'hA5A5_0000_0000_5A5A, "dual_bypass_rs2");
        step();
        idle();
        bus.rs2_addr = 5'd5;
        expect_v(K_RS1, 64'hA5A5_0000_0000_5A5A, "dual_array_rs1");
        expect_v(K_RS2, 64'hDEAD_BEEF, "reg5_retained");
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'h100);
        step();
        drive(1'b1, 1'b1, 1'b1, 5'd10, 64'h77, 64'h104);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'h108);
        step();
        idle();
        bus.rs1_addr = 5'd10;
        bus.rs2_addr = 5'd5;
        expect_v(K_INSTRET, 64'd3, "three_instret");
        expect_v(K_LOADRET, 64'd1, "three_loadret");
        expect_v(K_LASTPC, 64'h108, "three_last_pc");
        expect_v(K_RS1, 64'h77, "load_result");
        expect_v(K_RS2, 64'd0, "reg5_cleared_by_reset");
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h111, 64'h200);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h333, 64'h204);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        bus.rs1_addr = 5'd3;
        expect_v(K_RS1, 64'd0, "reset_beats_write");
        expect_v(K_INSTRET, 64'd0, "reset_beats_instret");
        expect_v(K_LASTPC, 64'd0, "reset_beats_last_pc");
`ifdef WB_COMMIT_TRACE_EN
        expect_v(K_TVALID, 64'd0, "reset_beats_trace");
`endif
        step();
        step();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
